// File: rtl/mem_writeback_stage.sv
// MEM/WB pipeline stage: captures memory-stage results and aligns load data for the
// register file. Also flags misaligned or illegal loads, feeds the bypass network and
// counts retired instructions.
module mem_writeback_stage #(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_Valid,
  input  logic                     i_Stall,
  input  logic                     i_Flush,
  input  logic                     i_RegWrite,
  input  logic [4:0]               i_RegDest,
  input  logic                     i_IsLoad,
  input  logic [2:0]               i_LoadFunct3,
  input  logic [31:0]              i_Address,
  input  logic [31:0]              i_LoadData,
  output logic                     o_WriteEnable,
  output logic [4:0]               o_RegDest,
  output logic [31:0]              o_DataOut,
  output logic                     o_FwdValid,
  output logic [4:0]               o_FwdRegDest,
  output logic [31:0]              o_FwdData,
  output logic                     o_Trap,
  output logic [31:0]              o_TrapAddr,
  output logic [COUNTER_WIDTH-1:0] o_RetiredCount
);

  localparam logic [2:0] F3Lb  = 3'd0;
  localparam logic [2:0] F3Lh  = 3'd1;
  localparam logic [2:0] F3Lw  = 3'd2;
  localparam logic [2:0] F3Lbu = 3'd4;
  localparam logic [2:0] F3Lhu = 3'd5;

  localparam logic [COUNTER_WIDTH-1:0] CountOne = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic                     valid_q;
  logic                     regwrite_q;
  logic [4:0]               regdest_q;
  logic                     isload_q;
  logic [2:0]               funct3_q;
  logic [31:0]              address_q;
  logic [31:0]              loaddata_q;
  logic                     loadheld_q;
  logic [COUNTER_WIDTH-1:0] count_q;

  logic        retire;
  logic        fault;
  logic        illegal_f3;
  logic        misaligned;
  logic        rd_writes;
  logic [31:0] load_word;
  logic [31:0] byte_shifted;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] data_out;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      regdest_q  <= 5'd0;
      isload_q   <= 1'b0;
      funct3_q   <= 3'd0;
      address_q  <= 32'd0;
      loaddata_q <= 32'd0;
      loadheld_q <= 1'b0;
    end else if (i_Flush) begin
      valid_q    <= 1'b0;
      loadheld_q <= 1'b0;
    end else if (!i_Stall) begin
      valid_q    <= i_Valid;
      regwrite_q <= i_RegWrite;
      regdest_q  <= i_RegDest;
      isload_q   <= i_IsLoad;
      funct3_q   <= i_LoadFunct3;
      address_q  <= i_Address;
      loadheld_q <= 1'b0;
    end else if (valid_q && isload_q && !loadheld_q) begin
      // The RAM read port only holds the word for one cycle; keep it across the stall.
      loaddata_q <= i_LoadData;
      loadheld_q <= 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count_q <= '0;
    end else if (retire && !fault) begin
      count_q <= count_q + CountOne;
    end
  end

  always_comb begin
    illegal_f3 = (funct3_q == 3'd3) || (funct3_q == 3'd6) || (funct3_q == 3'd7);
    misaligned = 1'b0;
    if ((funct3_q == F3Lh) || (funct3_q == F3Lhu)) begin
      misaligned = address_q[0];
    end else if (funct3_q == F3Lw) begin
      misaligned = (address_q[1:0] != 2'b00);
    end
    fault     = isload_q && (illegal_f3 || misaligned);
    retire    = valid_q && !i_Stall;
    rd_writes = regwrite_q && (regdest_q != 5'd0) && !fault;
  end

  always_comb begin
    load_word    = loadheld_q ? loaddata_q : i_LoadData;
    byte_shifted = load_word >> {address_q[1:0], 3'b000};
    load_byte    = byte_shifted[7:0];
    load_half    = address_q[1] ? load_word[31:16] : load_word[15:0];
    data_out     = address_q;
    if (isload_q) begin
      case (funct3_q)
        F3Lb:    data_out = {{24{load_byte[7]}}, load_byte};
        F3Lh:    data_out = {{16{load_half[15]}}, load_half};
        F3Lw:    data_out = load_word;
        F3Lbu:   data_out = {24'd0, load_byte};
        F3Lhu:   data_out = {16'd0, load_half};
        default: data_out = load_word;
      endcase
    end
  end

  assign o_WriteEnable  = retire && rd_writes;
  assign o_RegDest      = regdest_q;
  assign o_DataOut      = data_out;
  // Bypass ignores stall so a held result stays visible to younger instructions.
  assign o_FwdValid     = valid_q && rd_writes;
  assign o_FwdRegDest   = regdest_q;
  assign o_FwdData      = data_out;
  assign o_Trap         = retire && fault;
  assign o_TrapAddr     = (retire && fault) ? address_q : 32'd0;
  assign o_RetiredCount = count_q;

endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
- MEM/WB pipeline stage that sits directly upstream of the register file. It drives the register file's write enable, destination and data ports.
- Captures memory-stage results and aligns/sign-extends load data from the synchronous data RAM.
- Detects misaligned or illegal loads and raises a trap pulse.
- Provides a forwarding tap for the hazard/bypass unit and keeps a retired-instruction counter.

Parameters:
COUNTER_WIDTH, 32, width of o_RetiredCount (wraps modulo 2^COUNTER_WIDTH)

Ports:
i_Clock  input  1  clock; all state updates on rising edge
i_Reset_n  input  1  asynchronous, active-low reset
i_Valid  input  1  memory stage presents an instruction this cycle
i_Stall  input  1  hold stage contents; no capture, no retire
i_Flush  input  1  kill stage contents at next edge
i_RegWrite  input  1  instruction writes rd
i_RegDest  input  5  rd index
i_IsLoad  input  1  instruction is a load
i_LoadFunct3  input  3  0=LB 1=LH 2=LW 4=LBU 5=LHU
i_Address  input  32  ALU result / effective address
i_LoadData  input  32  RAM read word, valid the cycle after i_Address was presented
o_WriteEnable  output  1  to register file write enable
o_RegDest  output  5  to register file destination
o_DataOut  output  32  to register file data in
o_FwdValid  output  1  stage holds a valid rd-writing result (for bypass)
o_FwdRegDest  output  5  rd being forwarded
o_FwdData  output  32  value being forwarded (same as o_DataOut)
o_Trap  output  1  one-cycle pulse: retiring load misaligned or illegal funct3
o_TrapAddr  output  32  faulting address, valid with o_Trap
o_RetiredCount  output  COUNTER_WIDTH  count of instructions retired without trap

Behaviour:
- Reset (async, i_Reset_n=0): r_Valid=0, r_LoadHeld=0, counter=0; all outputs 0 while in reset and until the first capture.
- Capture: at an edge with i_Flush=0 and i_Stall=0, the stage registers all i_* fields and sets r_Valid=i_Valid.
- Flush: i_Flush=1 clears r_Valid and r_LoadHeld at the edge. Flush has priority over stall and capture.
- Stall: i_Stall=1 with i_Flush=0 holds all registers.
- Load hold: on the first stalled cycle of an occupied load (r_LoadHeld=0), latch i_LoadData into r_LoadData and set r_LoadHeld=1. While r_LoadHeld=1, alignment uses r_LoadData instead of i_LoadData. r_LoadHeld clears on capture.
- Retire: retire = r_Valid & ~i_Stall (combinational, in the cycle after capture). Latency is 1 cycle from i_Valid to the register-file write edge.
- Fault: fault = r_IsLoad & one of:
  - funct3 ∈ {3,6,7};
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]≠0.
- o_WriteEnable = retire & r_RegWrite & (r_RegDest≠0) & ~fault.
- o_Trap = retire & fault; o_TrapAddr = r_Address when o_Trap=1, else 0.
- Counter: increments by 1 when retire & ~fault; wraps from all-ones to 0.
- Data, non-load: o_DataOut = r_Address.
- Data, loads (little-endian):
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - On fault, o_DataOut is don't-care but must not write.
- Forwarding: o_FwdValid = r_Valid & r_RegWrite & (r_RegDest≠0) & ~fault. It is independent of i_Stall so the bypass still sees held results. o_FwdRegDest = r_RegDest; o_FwdData = o_DataOut.
- o_RegDest = r_RegDest at all times.
- Simultaneous events:
  - Flush+Stall: flush wins.
  - Retire and capture happen at the same edge (back-to-back flow, one instruction per cycle).
- Reset mid-stall: all state cleared immediately; no write issued.

Test Plan:
- Reset low, drive i_Valid=1 -> o_WriteEnable=0, o_RetiredCount=0. Release reset, ALU op rd=5, addr=0x1234_5678 -> next cycle o_WriteEnable=1, o_RegDest=5, o_DataOut=0x12345678; count=1.
- LB addr=0x103, i_LoadData=0x80FF_1122 -> o_DataOut=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr=0x102 -> 0xFFFF_80FF. LHU addr=0x100 -> 0x0000_1122.
- LW addr=0x102, rd=7 -> o_Trap=1, o_TrapAddr=0x102, o_WriteEnable=0, count unchanged. LH addr=0x101 -> trap. funct3=3 -> trap.
- LW rd=9 then i_Stall=1 for 3 cycles while i_LoadData changes to 0xDEAD_BEEF -> no write during stall, o_FwdValid=1. On release: write of the original word 0x8000_0001, not 0xDEADBEEF; count +1.
- Write to rd=0 -> o_WriteEnable=0, o_FwdValid=0, count +1. Flush asserted with Stall on an occupied stage -> next cycle r_Valid=0, no write, no trap.
- Counter preset near wrap (COUNTER_WIDTH=4, 15 retires then 1 more) -> o_RetiredCount goes 15->0. Ten back-to-back valid ops -> ten writes on ten consecutive edges.
